// File: rtl/ldpc_enc_ctrl_pkg.sv
// rtl/ldpc_enc_ctrl_pkg.sv - shared constants and FSM state type for the LDPC encoder frame controller
package ldpc_pkg;
  localparam int K_INFO  = 4320;
  localparam int N_PAR   = 360;
  localparam int GRP     = 360;
  localparam int CLR_CYC = 3;
  localparam int CNT_W   = 13;
  localparam int ADDR_W  = 9;

  typedef enum logic [1:0] {
    S_CLR  = 2'd0,
    S_INFO = 2'd1,
    S_WAIT = 2'd2,
    S_PAR  = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/ldpc_enc_ctrl_if.sv
// rtl/ldpc_enc_ctrl_if.sv - info-bit input, encoder-side and codeword-output signals of the frame controller
interface ldpc_enc_ctrl_if;
  import ldpc_pkg::*;

  logic              sin_valid;
  logic              sin_data;
  logic              sin_ready;
  logic              enc_rst_n;
  logic              enc_din_valid;
  logic              enc_din;
  logic [CNT_W-1:0]  enc_counter;
  logic [ADDR_W-1:0] enc_out_addr;
  logic              enc_data_valid_check;
  logic              enc_dout;
  logic              enc_calculate_finish;
  logic              cw_valid;
  logic              cw_data;
  logic              cw_sop;
  logic              cw_eop;

  modport master (
    input  sin_valid, sin_data, enc_dout, enc_calculate_finish,
    output sin_ready, enc_rst_n, enc_din_valid, enc_din, enc_counter,
           enc_out_addr, enc_data_valid_check, cw_valid, cw_data, cw_sop, cw_eop
  );

  modport slave (
    output sin_valid, sin_data, enc_dout, enc_calculate_finish,
    input  sin_ready, enc_rst_n, enc_din_valid, enc_din, enc_counter,
           enc_out_addr, enc_data_valid_check, cw_valid, cw_data, cw_sop, cw_eop
  );
endinterface

// File: rtl/ldpc_enc_ctrl_par_unload.sv
// rtl/ldpc_enc_ctrl_par_unload.sv - sweeps encoder out_addr 359..0 and forwards the parity bits as codeword beats
module ldpc_par_unload
  import ldpc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_enc_dout,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_data_valid_check,
  output logic              o_cw_valid,
  output logic              o_cw_data,
  output logic              o_cw_eop,
  output logic              o_done
);
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(N_PAR - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              r_dvc;
  logic              r_vld;
  logic              r_eop;
  logic              w_done;

  assign w_done = r_dvc & (r_addr == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= ADDR_TOP;
      r_dvc  <= 1'b0;
      r_vld  <= 1'b0;
      r_eop  <= 1'b0;
    end else begin
      r_vld <= r_dvc;
      r_eop <= w_done;
      if (i_start) begin
        r_dvc  <= 1'b1;
        r_addr <= ADDR_TOP;
      end else if (r_dvc) begin
        if (r_addr == '0) begin
          r_dvc  <= 1'b0;
          r_addr <= ADDR_TOP;
        end else begin
          r_addr <= r_addr - 1'b1;
        end
      end
    end
  end

  // enc_dout is already the encoder's output flop, so it rides with the delayed valid unregistered
  assign o_out_addr         = r_addr;
  assign o_data_valid_check = r_dvc;
  assign o_cw_valid         = r_vld;
  assign o_cw_data          = r_vld & i_enc_dout;
  assign o_cw_eop           = r_eop;
  assign o_done             = w_done;
endmodule

// File: rtl/ldpc_enc_ctrl.sv
// rtl/ldpc_enc_ctrl.sv - feeds 4320 info bits into the LDPC encoder, unloads 360 parity bits, emits the codeword
module ldpc_enc_ctrl
  import ldpc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  ldpc_enc_ctrl_if.master bus
);
  ctrl_state_t       r_state;
  logic [1:0]        r_clr_cnt;
  logic [CNT_W-1:0]  r_k;
  logic [CNT_W-1:0]  r_counter;
  logic              r_enc_rst_n;
  logic              r_sin_ready;
  logic              r_din_valid;
  logic              r_din;
  logic              r_sop;

  logic              w_xfer;
  logic              w_start;
  logic              w_done;
  logic              w_par_valid;
  logic              w_par_data;
  logic              w_par_eop;
  logic              w_dvc;
  logic [ADDR_W-1:0] w_out_addr;

  assign w_xfer  = r_sin_ready & bus.sin_valid;
  assign w_start = (r_state == S_WAIT) & bus.enc_calculate_finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLR;
      r_clr_cnt   <= '0;
      r_k         <= '0;
      r_counter   <= '0;
      r_enc_rst_n <= 1'b0;
      r_sin_ready <= 1'b0;
      r_din_valid <= 1'b0;
      r_din       <= 1'b0;
      r_sop       <= 1'b0;
    end else begin
      r_din_valid <= 1'b0;
      r_din       <= 1'b0;
      r_sop       <= 1'b0;
      case (r_state)
        S_CLR: begin
          r_counter <= '0;
          r_k       <= '0;
          if (r_clr_cnt == 2'(CLR_CYC - 1)) begin
            r_clr_cnt   <= '0;
            r_enc_rst_n <= 1'b1;
            r_sin_ready <= 1'b1;
            r_state     <= S_INFO;
          end else begin
            r_clr_cnt <= r_clr_cnt + 2'd1;
          end
        end
        S_INFO: begin
          // enc_counter only moves on a transfer, so it holds through input gaps
          if (w_xfer) begin
            r_din_valid <= 1'b1;
            r_din       <= bus.sin_data;
            r_counter   <= r_k;
            r_sop       <= (r_k == '0);
            r_k         <= r_k + 1'b1;
            if (r_k == CNT_W'(K_INFO - 1)) begin
              r_sin_ready <= 1'b0;
              r_state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_counter <= CNT_W'(K_INFO);
          if (bus.enc_calculate_finish) r_state <= S_PAR;
        end
        S_PAR: begin
          r_counter <= CNT_W'(K_INFO);
          if (w_done) begin
            r_enc_rst_n <= 1'b0;
            r_state     <= S_CLR;
          end
        end
        default: begin
          r_enc_rst_n <= 1'b0;
          r_sin_ready <= 1'b0;
          r_state     <= S_CLR;
        end
      endcase
    end
  end

  ldpc_par_unload u_par_unload (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start            (w_start),
    .i_enc_dout         (bus.enc_dout),
    .o_out_addr         (w_out_addr),
    .o_data_valid_check (w_dvc),
    .o_cw_valid         (w_par_valid),
    .o_cw_data          (w_par_data),
    .o_cw_eop           (w_par_eop),
    .o_done             (w_done)
  );

  assign bus.sin_ready            = r_sin_ready;
  assign bus.enc_rst_n            = r_enc_rst_n;
  assign bus.enc_din_valid        = r_din_valid;
  assign bus.enc_din              = r_din;
  assign bus.enc_counter          = r_counter;
  assign bus.enc_out_addr         = w_out_addr;
  assign bus.enc_data_valid_check = w_dvc;
  assign bus.cw_valid             = r_din_valid | w_par_valid;
  assign bus.cw_data              = w_par_valid ? w_par_data : r_din;
  assign bus.cw_sop               = r_sop;
  assign bus.cw_eop               = w_par_eop;
endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// tb/tb_ldpc_enc_ctrl.sv - directed frame tests of ldpc_enc_ctrl against a behavioural encoder stand-in
module tb_ldpc_enc_ctrl;
  localparam int K    = 4320;
  localparam int NP   = 360;
  localparam int MAXB = 32768;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ldpc_enc_ctrl_if bus ();
  ldpc_enc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic         tx_bits [K];
  logic         cw_bits [MAXB];
  logic [359:0] acc = '0;
  int  beat = 0, sop_cnt = 0, sop_pos = -1, eop_cnt = 0, eop_pos = -1;
  int  cyc = 0, eop_cyc = 0, fin_cyc = 0, fin_dly = 0, dvc_cnt = 0, hold_err = 0;
  int  low_run = 0, last_low_run = 0, ready_gap = 0, prev_ctr = 0;
  int  hits [12];
  int  hits0 [12];
  bit  prev_ready = 1'b0;
  bit  spur_req = 1'b0;
  int  b0, s0, e0, h0, d0;

  task automatic check(input string tag, input logic [359:0] got, input logic [359:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stand-in parity rule: each info bit folds into one parity position, rotated per 360-bit group
  function automatic int par_idx(input int k);
    return ((k % 360) + 13 * (k / 360)) % 360;
  endfunction

  always @(posedge clk) begin
    if (!bus.enc_rst_n) acc <= '0;
    else if (bus.enc_din_valid) acc[par_idx(int'(bus.enc_counter))] <= acc[par_idx(int'(bus.enc_counter))] ^ bus.enc_din;
    if (bus.enc_data_valid_check) bus.enc_dout <= acc[bus.enc_out_addr];
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.cw_valid) begin
        if (beat < MAXB) cw_bits[beat] = bus.cw_data;
        if (bus.cw_sop) begin sop_cnt++; sop_pos = beat; end
        if (bus.cw_eop) begin eop_cnt++; eop_pos = beat; eop_cyc = cyc; end
        beat++;
      end
      if (bus.enc_data_valid_check) dvc_cnt++;
      if (bus.enc_din_valid && (bus.enc_counter % 360) == 359 && bus.enc_counter < 4320)
        hits[bus.enc_counter / 360]++;
      if (bus.sin_ready && !bus.enc_din_valid && int'(bus.enc_counter) != prev_ctr) hold_err++;
      prev_ctr = int'(bus.enc_counter);
      if (!bus.enc_rst_n) low_run++;
      else if (low_run > 0) begin last_low_run = low_run; low_run = 0; end
      if (bus.sin_ready && !prev_ready) ready_gap = cyc - eop_cyc;
      prev_ready = bus.sin_ready;
    end else begin
      low_run = 0;
      prev_ready = 1'b0;
    end
    if (fin_dly > 0) fin_dly--;
    if (rst_n && bus.enc_din_valid && bus.enc_counter == 13'd4319) fin_dly = 4;
    if (fin_dly == 1) fin_cyc = cyc;
    bus.enc_calculate_finish = (fin_dly == 1) || spur_req;
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_sin_ready"}, bus.sin_ready, 0);
    check({pfx, "_enc_rst_n"}, bus.enc_rst_n, 0);
    check({pfx, "_enc_counter"}, bus.enc_counter, 0);
    check({pfx, "_out_addr"}, bus.enc_out_addr, 359);
    check({pfx, "_others"}, {bus.enc_din_valid, bus.enc_din, bus.enc_data_valid_check,
                             bus.cw_valid, bus.cw_data, bus.cw_sop, bus.cw_eop}, 0);
  endtask

  task automatic snapshot();
    b0 = beat; s0 = sop_cnt; e0 = eop_cnt; h0 = hold_err; d0 = dvc_cnt;
    hits0 = hits;
  endtask

  task automatic send_frame(input int max_gap, input int spur_at, input int abort_at);
    int gap;
    int guard;
    for (int k = 0; k < K; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.sin_valid = 1'b0;
      repeat (gap) @(negedge clk);
      if (k == spur_at) begin
        spur_req = 1'b1;
        repeat (2) @(negedge clk);
        spur_req = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_dvc", bus.enc_data_valid_check, 0);
        check("spur_ready", bus.sin_ready, 1);
      end
      bus.sin_valid = 1'b1;
      bus.sin_data  = tx_bits[k];
      guard = 0;
      while (!bus.sin_ready && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 5000) begin
        check("ready_timeout", guard, 0);
        bus.sin_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (k == abort_at) begin
        bus.sin_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid");
        return;
      end
    end
    bus.sin_valid = 1'b0;
  endtask

  task automatic wait_eop();
    int guard = 0;
    while (eop_cnt == e0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("eop_seen", eop_cnt - e0, 1);
  endtask

  task automatic check_frame(input string tag, input bit follow);
    logic [359:0] exp_par;
    logic [359:0] got_par;
    int mism = 0;
    int ones = 0;
    exp_par = '0;
    for (int k = 0; k < K; k++) begin
      exp_par[par_idx(k)] = exp_par[par_idx(k)] ^ tx_bits[k];
      if (cw_bits[b0 + k] !== tx_bits[k]) mism++;
    end
    for (int i = 0; i < NP; i++) got_par[NP - 1 - i] = cw_bits[b0 + K + i];
    for (int j = 0; j < 12; j++) if (hits[j] - hits0[j] == 1) ones++;
    check({tag, "_beats"}, beat - b0, 4680);
    check({tag, "_sop_cnt"}, sop_cnt - s0, 1);
    check({tag, "_sop_pos"}, sop_pos - b0, 0);
    check({tag, "_eop_pos"}, eop_pos - b0, 4679);
    check({tag, "_info_mism"}, mism, 0);
    check({tag, "_parity"}, got_par, exp_par);
    check({tag, "_ctr_group_ends"}, ones, 12);
    check({tag, "_ctr_hold"}, hold_err - h0, 0);
    check({tag, "_dvc_cycles"}, dvc_cnt - d0, 360);
    check({tag, "_fin_to_eop"}, eop_cyc - fin_cyc, 361);
    if (follow) begin
      check({tag, "_clr_low"}, last_low_run, 3);
      check({tag, "_eop_to_ready"}, ready_gap, 3);
    end
  endtask

  initial begin
    logic [359:0] got_row;
    for (int j = 0; j < 12; j++) hits[j] = 0;
    rst_n = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin_data  = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < K; k++) tx_bits[k] = 1'b0;
    snapshot();
    send_frame(0, -1, -1);
    wait_eop();
    check_frame("zero", 1'b0);

    for (int k = 0; k < K; k++) tx_bits[k] = (k == 0);
    snapshot();
    send_frame(0, -1, -1);
    wait_eop();
    check_frame("row0", 1'b1);
    for (int i = 0; i < NP; i++) got_row[NP - 1 - i] = cw_bits[b0 + K + i];
    check("row0_vector", got_row, 360'd1);

    for (int k = 0; k < K; k++) tx_bits[k] = 1'($urandom_range(1, 0));
    snapshot();
    send_frame(5, 100, -1);
    wait_eop();
    check_frame("gaps", 1'b1);

    for (int k = 0; k < K; k++) tx_bits[k] = 1'($urandom_range(1, 0));
    snapshot();
    send_frame(0, -1, 2000);
    repeat (5) @(negedge clk);
    check("abort_no_eop", eop_cnt - e0, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < K; k++) tx_bits[k] = 1'($urandom_range(1, 0));
    snapshot();
    send_frame(2, -1, -1);
    wait_eop();
    check_frame("post_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ldpc_enc_ctrl.md
# ldpc_enc_ctrl

Frame controller that sits directly upstream of the LDPC parity encoder (`encoder1`) and also collects its output. It accepts a serial info-bit stream through a valid/ready handshake and drives the encoder's `din_valid`/`din`/`counter` inputs. After the encoder signals `calculate_finish`, it sweeps `out_addr` to unload the 360 parity bits. It emits one systematic codeword stream of 4320 info bits followed by 360 parity bits, and re-clears the encoder between frames.

## Interface
- `K_INFO`, 4320: info bits per frame (12 groups × 360).
- `N_PAR`, 360: parity bits per frame.
- `CLR_CYC`, 3: encoder-clear cycles (covers counter→addra→ROM latency).
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `sin_valid` in 1: info bit available.
- `sin_data` in 1: info bit.
- `sin_ready` out 1: block accepts a bit; transfer = `sin_valid & sin_ready`.
- `enc_rst_n` out 1: synchronous clear to encoder, active low.
- `enc_din_valid` out 1: to encoder `din_valid`.
- `enc_din` out 1: to encoder `din`.
- `enc_counter` out 13: to encoder `counter`; index of the bit on `enc_din`.
- `enc_out_addr` out 9: to encoder `out_addr`.
- `enc_data_valid_check` out 1: to encoder `data_valid_check`.
- `enc_dout` in 1: from encoder `dout`; registered, 1-cycle latency.
- `enc_calculate_finish` in 1: from encoder.
- `cw_valid` out 1: codeword bit valid.
- `cw_data` out 1: codeword bit.
- `cw_sop` out 1: first bit of codeword (info bit 0).
- `cw_eop` out 1: last bit of codeword (parity bit `out_addr`=0).

## Operation
- FSM states: S_CLR → S_INFO → S_WAIT → S_PAR → S_CLR.
- S_CLR:
  - `enc_rst_n`=0, `enc_counter`=0, `sin_ready`=0 for `CLR_CYC` cycles.
  - Then S_INFO with `enc_rst_n`=1.
- S_INFO:
  - `sin_ready`=1 (Moore; depends only on state).
  - Bit counter `k` runs 0..4319.
  - On each transfer, the next cycle shows: `enc_din_valid`=1, `enc_din`=`sin_data`, `enc_counter`=k, `cw_valid`=1, `cw_data`=`sin_data`, `cw_sop`=(k==0). `k` then increments.
  - No transfer: `enc_din_valid`=0, `cw_valid`=0, `enc_counter` holds. Gaps of any length are legal.
  - Transfer of k=4319 moves to S_WAIT.
- S_WAIT:
  - `sin_ready`=0, `enc_counter`=4320.
  - Move to S_PAR on the cycle `enc_calculate_finish`=1 is sampled.
- S_PAR:
  - `enc_data_valid_check`=1 for exactly 360 consecutive cycles.
  - `enc_out_addr` counts 359 down to 0.
  - Each `enc_dout` sampled 1 cycle later is presented as `cw_data` with `cw_valid`=1. No gaps; no output backpressure.
  - `cw_eop`=1 with the bit for address 0. The FSM then enters S_CLR.
  - `enc_data_valid_check` returns to 0 in the cycle after address 0.
- Codeword length is exactly 4680 `cw_valid` beats. Parity order is MSB first (address 359 first).
- `enc_counter` never skips a value within a frame. Counter values 359, 719, …, 4319 therefore occur exactly once each.

## Timing
- Reset values:
  - FSM S_CLR; clear-cycle count 0.
  - `enc_rst_n`=0, `enc_counter`=0, `enc_out_addr`=359.
  - All other outputs 0.
- Info path latency: `sin` transfer to `cw`/`enc_din` = 1 cycle.
- Parity path:
  - `enc_calculate_finish` high in cycle T.
  - `enc_data_valid_check` high from T+1.
  - First parity `cw_valid` at T+2.
  - Last parity beat (`cw_eop`) at T+361.
- Frame-to-frame gap:
  - `cw_eop` → `sin_ready` rises `CLR_CYC` cycles later.
  - Minimum frame period is 4320 + 1 + 361 + `CLR_CYC` cycles with no input gaps.
- `enc_calculate_finish` seen outside S_WAIT: ignored.
- Async reset mid-frame:
  - Outputs return to reset values immediately; the partial frame is discarded.
  - No `cw_eop` is emitted for it.
  - The encoder is cleared by S_CLR after release.

## Structure
- Package `ldpc_pkg`:
  - `K_INFO`, `N_PAR`, `GRP`=360.
  - Counter widths 13/9.
  - FSM state enum `ctrl_state_t`.
- One sub-module, `ldpc_par_unload`:
  - 360-cycle down-counter that generates `enc_out_addr`/`enc_data_valid_check`.
  - 1-cycle delayed capture of `enc_dout` into `cw_data`/`cw_valid`/`cw_eop`.
  - Started by a one-cycle `start` pulse; returns a `done` pulse.

## Test plan
- All-zero frame, continuous `sin_valid`:
  - 4680 `cw_valid` beats.
  - `cw_sop` on beat 0; all data 0; `cw_eop` on beat 4679.
- Single 1 at k=0:
  - Parity equals the golden G-row-0 vector, emitted bit 359 first.
  - `enc_counter` hits 359/719/…/4319 once each.
- Random data with random `sin_valid` gaps of 0–5 cycles:
  - Parity matches the golden model.
  - `enc_counter` holds during gaps.
- Two back-to-back frames:
  - Second frame's parity is independent of the first.
  - `enc_rst_n` is low for 3 cycles between them.
- `rst_n` asserted at k=2000:
  - All outputs at reset values the same cycle.
  - The next full frame encodes correctly.
- Spurious `enc_calculate_finish` during S_INFO: no effect; `enc_data_valid_check` stays 0.
